// File: rtl/dc_fu_fetch_ctrl.sv
// Line fetch controller for the display pixel pipeline: turns a frame descriptor
// into beat-aligned AXI read bursts, one line at a time, never crossing a 4 KB page.
module dc_fu_fetch_ctrl #(
    parameter int ADDR_WIDTH     = 32,
    parameter int READ_DATA_SIZE = 1,
    parameter int BITS_PER_PIXEL = 24,
    parameter int MAX_BURST_LEN  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  frame_start,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [11:0]           cfg_width,
    input  logic [11:0]           cfg_height,
    input  logic                  line_req,
    output logic                  axi_arvalid,
    input  logic                  axi_arready,
    output logic [ADDR_WIDTH-1:0] axi_araddr,
    output logic [7:0]            axi_arlen,
    output logic [2:0]            axi_arsize,
    output logic [1:0]            axi_arburst,
    input  logic                  axi_rvalid,
    input  logic                  axi_rlast,
    output logic                  axi_rready,
    output logic                  fetch_in_progress,
    output logic                  unaligned_read,
    output logic                  line_done,
    output logic                  frame_done,
    output logic                  busy
);

    localparam int                    BEAT_BYTES = 1 << READ_DATA_SIZE;
    localparam logic [ADDR_WIDTH-1:0] BEAT_MASK  = ADDR_WIDTH'(BEAT_BYTES - 1);
    localparam logic [13:0]           MAX_BEATS  = 14'(MAX_BURST_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LINE_WAIT,
        S_ADDR,
        S_DATA,
        S_LINE_END
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH-1:0]   stride_q, stride_d;
    logic [11:0]             width_q, width_d;
    logic [11:0]             height_q, height_d;
    logic [11:0]             line_idx_q, line_idx_d;
    logic [ADDR_WIDTH-1:0]   burst_addr_q, burst_addr_d;
    logic [13:0]             beats_rem_q, beats_rem_d;
    logic                    unaligned_q, unaligned_d;

    logic [ADDR_WIDTH-1:0]   line_addr;
    logic [ADDR_WIDTH-1:0]   line_offset;
    logic [31:0]             line_bits;
    logic [13:0]             line_beats;
    logic [13:0]             page_beats;
    logic [13:0]             burst_beats;
    logic [ADDR_WIDTH-1:0]   burst_bytes;

    // Line geometry: the beat count covers the leading pad bytes of an unaligned start.
    always_comb begin
        line_addr   = base_q + ADDR_WIDTH'(line_idx_q) * stride_q;
        line_offset = line_addr & BEAT_MASK;
        line_bits   = 32'(width_q) * 32'(BITS_PER_PIXEL) + 32'(line_offset) * 32'd8;
        line_beats  = 14'((line_bits + 32'(8 * BEAT_BYTES - 1)) >> (READ_DATA_SIZE + 3));
    end

    // Burst size is the tightest of: what is left of the line, the burst cap, the page end.
    always_comb begin
        page_beats  = 14'((14'h1000 - {2'b00, burst_addr_q[11:0]}) >> READ_DATA_SIZE);
        burst_beats = beats_rem_q;
        if (MAX_BEATS < burst_beats) begin
            burst_beats = MAX_BEATS;
        end
        if (page_beats < burst_beats) begin
            burst_beats = page_beats;
        end
        burst_bytes = ADDR_WIDTH'(burst_beats) << READ_DATA_SIZE;
    end

    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        stride_d     = stride_q;
        width_d      = width_q;
        height_d     = height_q;
        line_idx_d   = line_idx_q;
        burst_addr_d = burst_addr_q;
        beats_rem_d  = beats_rem_q;
        unaligned_d  = unaligned_q;
        line_done    = 1'b0;
        frame_done   = 1'b0;

        if (en) begin
            case (state_q)
                S_IDLE: begin
                    if (frame_start) begin
                        base_d     = cfg_base;
                        stride_d   = cfg_stride;
                        width_d    = cfg_width;
                        height_d   = cfg_height;
                        line_idx_d = '0;
                        state_d    = S_LINE_WAIT;
                    end
                end
                S_LINE_WAIT: begin
                    if (width_q == '0 || height_q == '0) begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end else if (line_req) begin
                        burst_addr_d = line_addr & ~BEAT_MASK;
                        beats_rem_d  = line_beats;
                        unaligned_d  = (line_offset != '0);
                        state_d      = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (axi_arready) begin
                        burst_addr_d = burst_addr_q + burst_bytes;
                        beats_rem_d  = beats_rem_q - burst_beats;
                        state_d      = S_DATA;
                    end
                end
                S_DATA: begin
                    // Only one burst is ever outstanding, so rlast closes the one we issued.
                    if (axi_rvalid && axi_rlast) begin
                        state_d = (beats_rem_q != '0) ? S_ADDR : S_LINE_END;
                    end
                end
                S_LINE_END: begin
                    line_done  = 1'b1;
                    line_idx_d = line_idx_q + 12'd1;
                    if (({1'b0, line_idx_q} + 13'd1) == {1'b0, height_q}) begin
                        frame_done = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        state_d = S_LINE_WAIT;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            base_q       <= '0;
            stride_q     <= '0;
            width_q      <= '0;
            height_q     <= '0;
            line_idx_q   <= '0;
            burst_addr_q <= '0;
            beats_rem_q  <= '0;
            unaligned_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            base_q       <= base_d;
            stride_q     <= stride_d;
            width_q      <= width_d;
            height_q     <= height_d;
            line_idx_q   <= line_idx_d;
            burst_addr_q <= burst_addr_d;
            beats_rem_q  <= beats_rem_d;
            unaligned_q  <= unaligned_d;
        end
    end

    // AR fields are driven only while a request is pending so idle outputs read as zero.
    assign axi_arvalid       = en && (state_q == S_ADDR);
    assign axi_araddr        = (state_q == S_ADDR) ? burst_addr_q : '0;
    assign axi_arlen         = (state_q == S_ADDR) ? 8'(burst_beats - 14'd1) : 8'd0;
    assign axi_arsize        = 3'(READ_DATA_SIZE);
    assign axi_arburst       = 2'b01;
    assign axi_rready        = en && (state_q == S_DATA);
    assign fetch_in_progress = (state_q == S_ADDR) || (state_q == S_DATA);
    assign unaligned_read    = unaligned_q;
    assign busy              = (state_q != S_IDLE);

endmodule

// File: doc/dc_fu_fetch_ctrl.md
DC_FU_FETCH_CTRL -- requirements
Module: dc_fu_fetch_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 32, AXI address width; READ_DATA_SIZE, default 1, log2 of bytes per beat (16-bit bus); BITS_PER_PIXEL, default 24, packed pixel width; MAX_BURST_LEN, default 16, maximum beats per burst (power of two, 1..256).
REQ-002 SHALL have ports, in order:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  global enable.
- frame_start  in  1  one-cycle start pulse.
- cfg_base  in  ADDR_WIDTH  frame byte address.
- cfg_stride  in  ADDR_WIDTH  line pitch, bytes.
- cfg_width  in  12  pixels per line.
- cfg_height  in  12  lines per frame.
- line_req  in  1  downstream has room for one line.
- axi_arvalid  out  1  AR valid.
- axi_arready  in  1  AR ready.
- axi_araddr  out  ADDR_WIDTH  burst start address.
- axi_arlen  out  8  beats minus one.
- axi_arsize  out  3  constant READ_DATA_SIZE.
- axi_arburst  out  2  constant 2'b01 (INCR).
- axi_rvalid  in  1  R valid.
- axi_rlast  in  1  R last.
- axi_rready  out  1  R ready.
- fetch_in_progress  out  1  line fetch active (to pixel unpack).
- unaligned_read  out  1  line start not beat-aligned (to pixel unpack).
- line_done  out  1  one-cycle pulse, last beat of a line received.
- frame_done  out  1  one-cycle pulse, frame complete.
- busy  out  1  state not IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, LINE_WAIT, ADDR, DATA, LINE_END; all registers update only when en=1.
REQ-004 IDLE: on frame_start SHALL latch cfg_* into shadow registers, clear line counter, go LINE_WAIT; frame_start in any other state SHALL be ignored.
REQ-005 LINE_WAIT: if shadow width=0 or height=0, SHALL pulse frame_done and go IDLE without issuing AR; else on line_req SHALL load line address = base + line_index*stride and go ADDR.
REQ-006 At line load: byte offset = line address mod 2^READ_DATA_SIZE; unaligned_read SHALL equal (offset!=0), held until next line load; beats_remaining SHALL = ceil((offset + width*BITS_PER_PIXEL/8) / 2^READ_DATA_SIZE), 14-bit unsigned.
REQ-007 Burst address SHALL be beat-aligned (low READ_DATA_SIZE bits zero); first burst of a line uses line address aligned down.
REQ-008 Burst beats SHALL = min(beats_remaining, MAX_BURST_LEN, beats to next 4 KB boundary); axi_arlen = beats-1; no burst crosses a 4 KB boundary.
REQ-009 ADDR: axi_arvalid = en; araddr/arlen SHALL remain stable until handshake; on arvalid&arready SHALL go DATA, advance burst address by beats*2^READ_DATA_SIZE, subtract beats from beats_remaining.
REQ-010 DATA: axi_rready = en; on rvalid&rready&rlast SHALL go ADDR if beats_remaining>0, else LINE_END; at most one burst outstanding.
REQ-011 LINE_END: SHALL pulse line_done, increment line_index; if line_index+1 = height SHALL pulse frame_done in the same cycle and go IDLE, else go LINE_WAIT.
REQ-012 fetch_in_progress SHALL be 1 in ADDR and DATA only; SHALL fall the cycle after the final rlast of the line.
REQ-013 axi_arvalid and axi_rready SHALL be 0 in all other states; axi_arsize/axi_arburst constant.
REQ-014 en=0 SHALL freeze state and counters, force arvalid=0 and rready=0; outputs line_done/frame_done SHALL not pulse.
REQ-015 Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-016 rst=1 at a rising edge SHALL force IDLE, clear counters and shadows, all outputs 0 except axi_arsize=READ_DATA_SIZE, axi_arburst=2'b01; applies mid-burst, outstanding R beats afterwards ignored (rready=0).

Verification
REQ-017 base 0x1000, stride 16, width 4, height 2 -> AR 0x1000 arlen 5, AR 0x1010 arlen 5, unaligned_read=0, two line_done, frame_done with second line_done.
REQ-018 base 0x1001, width 1, height 1 -> AR 0x1000 arlen 1, unaligned_read=1 during fetch.
REQ-019 base 0x1000, width 16, MAX_BURST_LEN 16 -> AR 0x1000 arlen 15, then AR 0x1020 arlen 7; fetch_in_progress high throughout.
REQ-020 base 0x0FF8, width 8 -> AR 0x0FF8 arlen 3, then AR 0x1000 arlen 7.
REQ-021 width 0 -> no AR, frame_done pulse one cycle after line_req-independent LINE_WAIT entry; frame_start during busy ignored.
REQ-022 rst asserted mid-DATA -> next cycle IDLE, arvalid=rready=fetch_in_progress=0; new frame_start runs normally.
